baccarat_ctrl: RTL and testbench

Sequencing controller for the baccarat card datapath. It issues the six one-hot card-load strobes in dealing order, applies the Punto Banco third-card rules to the datapath's score and third-card feedback, and drives the player/dealer win lights when the hand ends. It shares the datapath's slow clock and has no other timing source.

---
 rtl/baccarat_ctrl.sv | 126 ++++++++++++
 tb/tb_baccarat_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/baccarat_ctrl.sv
// rtl/baccarat_ctrl.sv - Punto Banco dealing sequencer and third-card rule controller
//
// Purpose: steps the card datapath through the deal, decides third-card
// draws from the datapath's running totals, and lights the winner.
//
// Ports:
//   slow_clock        in   shared clock with the card datapath
//   resetb            in   asynchronous active-low reset, returns to IDLE
//   pscore[3:0]       in   player total (mod 10)
//   dscore[3:0]       in   dealer total (mod 10)
//   pcard3[3:0]       in   raw code of player's third card (0 = empty)
//   load_pcard1..3    out  player card register load strobes
//   load_dcard1..3    out  dealer card register load strobes
//   player_win_light  out  player wins or tie (DONE only)
//   dealer_win_light  out  dealer wins or tie (DONE only)

module baccarat_ctrl (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEAL_P1,
    S_DEAL_D1,
    S_DEAL_P2,
    S_DEAL_D2,
    S_CHECK,
    S_P_DRAW,
    S_BANK_CHECK,
    S_D_DRAW,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_pval;
  logic       w_bank_draw;
  logic       r_load_pcard1, r_load_pcard2, r_load_pcard3;
  logic       r_load_dcard1, r_load_dcard2, r_load_dcard3;

  // Face cards and tens count as zero; out-of-range codes fold to zero too.
  always_comb begin
    w_pval = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
  end

  // Banker's response to the player's third card.
  always_comb begin
    w_bank_draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: w_bank_draw = 1'b1;
      4'd3:             w_bank_draw = (w_pval != 4'd8);
      4'd4:             w_bank_draw = (w_pval >= 4'd2) && (w_pval <= 4'd7);
      4'd5:             w_bank_draw = (w_pval >= 4'd4) && (w_pval <= 4'd7);
      4'd6:             w_bank_draw = (w_pval >= 4'd6) && (w_pval <= 4'd7);
      default:          w_bank_draw = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = S_DEAL_P1;
      S_DEAL_P1:    w_next = S_DEAL_D1;
      S_DEAL_D1:    w_next = S_DEAL_P2;
      S_DEAL_P2:    w_next = S_DEAL_D2;
      S_DEAL_D2:    w_next = S_CHECK;
      S_CHECK: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) w_next = S_DONE;
        else if (pscore <= 4'd5)                   w_next = S_P_DRAW;
        else if (dscore <= 4'd5)                   w_next = S_D_DRAW;
        else                                       w_next = S_DONE;
      end
      S_P_DRAW:     w_next = S_BANK_CHECK;
      S_BANK_CHECK: w_next = w_bank_draw ? S_D_DRAW : S_DONE;
      S_D_DRAW:     w_next = S_DONE;
      S_DONE:       w_next = S_DONE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one is a clean
  // flop output that still equals a decode of the current state.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= S_IDLE;
      r_load_pcard1 <= 1'b0;
      r_load_pcard2 <= 1'b0;
      r_load_pcard3 <= 1'b0;
      r_load_dcard1 <= 1'b0;
      r_load_dcard2 <= 1'b0;
      r_load_dcard3 <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_load_pcard1 <= (w_next == S_DEAL_P1);
      r_load_dcard1 <= (w_next == S_DEAL_D1);
      r_load_pcard2 <= (w_next == S_DEAL_P2);
      r_load_dcard2 <= (w_next == S_DEAL_D2);
      r_load_pcard3 <= (w_next == S_P_DRAW);
      r_load_dcard3 <= (w_next == S_D_DRAW);
    end
  end

  assign load_pcard1 = r_load_pcard1;
  assign load_pcard2 = r_load_pcard2;
  assign load_pcard3 = r_load_pcard3;
  assign load_dcard1 = r_load_dcard1;
  assign load_dcard2 = r_load_dcard2;
  assign load_dcard3 = r_load_dcard3;

  // Lights follow the live totals while in DONE so they track the datapath.
  assign player_win_light = (r_state == S_DONE) && (pscore >= dscore);
  assign dealer_win_light = (r_state == S_DONE) && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_ctrl.sv
// tb/tb_baccarat_ctrl.sv - randomized self-checking bench for baccarat_ctrl

module tb_baccarat_ctrl;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  baccarat_ctrl dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  always #5 slow_clock = ~slow_clock;

  localparam int P1 = 128, P2 = 64, P3 = 32, D1 = 16, D2 = 8, D3 = 4, PW = 2, DW = 1;

  int n_vec = 0;
  int n_err = 0;

  // Cards on offer for the current hand, and the emulated datapath registers.
  int cur_p[3];
  int cur_d[3];
  int dp_p1, dp_p2, dp_p3, dp_d1, dp_d2, dp_d3;

  function automatic int cv(input int c);
    return (c >= 10) ? 0 : c;
  endfunction

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      dp_p1 <= 0; dp_p2 <= 0; dp_p3 <= 0;
      dp_d1 <= 0; dp_d2 <= 0; dp_d3 <= 0;
    end else begin
      if (load_pcard1) dp_p1 <= cur_p[0];
      if (load_pcard2) dp_p2 <= cur_p[1];
      if (load_pcard3) dp_p3 <= cur_p[2];
      if (load_dcard1) dp_d1 <= cur_d[0];
      if (load_dcard2) dp_d2 <= cur_d[1];
      if (load_dcard3) dp_d3 <= cur_d[2];
    end
  end

  assign pscore = 4'((cv(dp_p1) + cv(dp_p2) + cv(dp_p3)) % 10);
  assign dscore = 4'((cv(dp_d1) + cv(dp_d2) + cv(dp_d3)) % 10);
  assign pcard3 = 4'(dp_p3);

  wire [7:0] outv = {load_pcard1, load_pcard2, load_pcard3,
                     load_dcard1, load_dcard2, load_dcard3,
                     player_win_light, dealer_win_light};

  // Banker chart: row = banker two-card total, column = player third-card value.
  string bank_chart[10] = '{
    "DDDDDDDDDD", "DDDDDDDDDD", "DDDDDDDDDD", "DDDDDDDDSD",
    "SSDDDDDDSS", "SSSSDDDDSS", "SSSSSSDDSS", "SSSSSSSSSS",
    "SSSSSSSSSS", "SSSSSSSSSS"};

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Plays one hand from reset and compares every cycle's outputs.
  task automatic run_hand(input int p1, input int p2, input int p3,
                          input int d1, input int d2, input int d3,
                          input string name);
    int ev[12];
    int pt, dt, pf, df, done_at;
    bit pdraw, ddraw;
    cur_p[0] = p1; cur_p[1] = p2; cur_p[2] = p3;
    cur_d[0] = d1; cur_d[1] = d2; cur_d[2] = d3;
    foreach (ev[i]) ev[i] = 0;
    ev[1] = P1; ev[2] = D1; ev[3] = P2; ev[4] = D2;
    pt = (cv(p1) + cv(p2)) % 10;
    dt = (cv(d1) + cv(d2)) % 10;
    pdraw = 0; ddraw = 0;
    if (pt >= 8 || dt >= 8) begin
      done_at = 6;
    end else if (pt <= 5) begin
      pdraw = 1;
      ev[6] = P3;
      ddraw = (bank_chart[dt].getc(cv(p3)) == "D");
      if (ddraw) begin ev[8] = D3; done_at = 9; end
      else done_at = 8;
    end else if (dt <= 5) begin
      ddraw = 1;
      ev[6] = D3;
      done_at = 7;
    end else begin
      done_at = 6;
    end
    pf = pdraw ? (pt + cv(p3)) % 10 : pt;
    df = ddraw ? (dt + cv(d3)) % 10 : dt;
    for (int n = done_at; n < 12; n++)
      ev[n] = (pf >= df ? PW : 0) | (df >= pf ? DW : 0);

    @(negedge slow_clock);
    resetb = 1'b0;
    #1 check_eq({name, ":in_reset"}, int'(outv), 0);
    @(negedge slow_clock);
    resetb = 1'b1;
    #1 check_eq({name, ":idle"}, int'(outv), 0);
    for (int n = 1; n < 12; n++) begin
      @(negedge slow_clock);
      check_eq($sformatf("%s:edge%0d", name, n), int'(outv), ev[n]);
      check_eq($sformatf("%s:onehot%0d", name, n), int'($countones(outv[7:2]) <= 1), 1);
    end
  endtask

  initial begin
    int d3r;
    // Asynchronous reset while in DEAL_D1.
    cur_p = '{1, 2, 3}; cur_d = '{4, 5, 6};
    @(negedge slow_clock);
    resetb = 1'b1;
    @(negedge slow_clock);
    check_eq("mid:p1", int'(outv), P1);
    @(negedge slow_clock);
    check_eq("mid:d1", int'(outv), D1);
    #2 resetb = 1'b0;
    #1 check_eq("mid:async_clear", int'(outv), 0);
    @(negedge slow_clock);
    check_eq("mid:held", int'(outv), 0);
    run_hand(1, 2, 3, 4, 5, 6, "restart");

    // Directed hands.
    run_hand(8, 10, 5, 3, 10, 5, "natural");
    run_hand(6, 10, 5, 4, 10, 5, "pstand_ddraw");
    run_hand(2, 10, 5, 6, 10, 5, "pdraw_dstand");
    run_hand(2, 10, 3, 2, 10, 3, "tie55");

    // Banker rule sweep: player totals 0 so the player always draws.
    for (int ds = 3; ds <= 6; ds++)
      for (int c = 1; c <= 13; c++) begin
        d3r = int'($urandom_range(1, 13));
        run_hand(10, 10, c, ds, 10, d3r, $sformatf("sweep_d%0d_c%0d", ds, c));
      end

    // Random shoes.
    for (int h = 0; h < 300; h++)
      run_hand(int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
               int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
               int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
               $sformatf("rand%0d", h));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
